fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, bubble encoding (addi x0,x0,0).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rstn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  out  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  in  1  response valid, in request order, no backpressure.
REQ-009 SHALL have port imem_rsp_data  in  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse.
REQ-011 SHALL have port redirect_pc  in  32  redirect target.
REQ-012 SHALL have port stall_Ps2  in  1  decode holds the Ps2 instruction.
REQ-013 SHALL have port InstructionPs2  out  32  registered instruction to decode.
REQ-014 SHALL have port PcPs2  out  32  PC of InstructionPs2.
REQ-015 SHALL have port ValidPs2  out  1  InstructionPs2 is a real fetched instruction.

Function
REQ-016 SHALL keep a fetch PC register; request handshake (req_valid & req_ready) advances PC by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 SHALL drive imem_req_addr = fetch PC, bits [1:0] always 0; redirect_pc[1:0] ignored.
REQ-018 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, except on redirect.
REQ-019 SHALL buffer responses in a 2-entry in-order FIFO; tag PC of each entry stored with the word.
REQ-020 SHALL assert imem_req_valid only when (in-flight count + FIFO count) < 2, guaranteeing every response has a FIFO slot; in-flight count max 2.
REQ-021 SHALL, when stall_Ps2=0, load Ps2 registers from FIFO head (ValidPs2=1, pop) if FIFO non-empty, or from an imem response arriving this cycle if FIFO empty (bypass, 1-cycle rsp-to-Ps2 latency); otherwise load NOP_INSTR with ValidPs2=0 and hold PcPs2.
REQ-022 SHALL, when stall_Ps2=1, hold InstructionPs2, PcPs2, ValidPs2 unchanged; responses still enter FIFO.
REQ-023 SHALL implement FSM RUN/DRAIN: RUN normal; redirect with in-flight>0 -> DRAIN with discard count = in-flight requests including one handshaking in the redirect cycle; DRAIN drops each response and decrements; count 0 -> RUN.
REQ-024 SHALL on redirect_valid: load fetch PC with redirect_pc, flush FIFO, force ValidPs2=0/NOP_INSTR next cycle regardless of stall_Ps2; redirect has priority over every simultaneous event.
REQ-025 SHALL allow new requests in DRAIN, subject to REQ-020 counting discards as in-flight; responses beyond discard count are kept.
REQ-026 SHALL treat redirect during DRAIN as adding newly issued in-flight requests to the discard count.
REQ-027 SHALL not drop or duplicate any non-discarded response; FIFO full plus arriving response is impossible by REQ-020.

Reset
REQ-028 SHALL on rstn=0 asynchronously set: fetch PC=RESET_PC, FIFO empty, in-flight=0, discard=0, FSM=RUN, imem_req_valid=0, InstructionPs2=NOP_INSTR, PcPs2=RESET_PC, ValidPs2=0.
REQ-029 SHALL assert imem_req_valid no earlier than the first clock edge after rstn deassertion.
REQ-030 SHALL on reset mid-operation abandon in-flight requests; responses arriving while rstn=0 ignored.

Verification
REQ-031 Reset release, req_ready=1, 1-cycle memory -> addrs 0,4,8,... ; ValidPs2=1 with PcPs2=0 two cycles after first request.
REQ-032 stall_Ps2=1 for 5 cycles -> at most 2 requests outstanding/buffered, InstructionPs2 held, no lost words after release, PcPs2 consecutive.
REQ-033 redirect_pc=32'h0000_0103 with 2 in-flight -> next address 32'h100, 2 stale responses dropped, first ValidPs2 shows PcPs2=32'h100.
REQ-034 req_ready=0 for 3 cycles -> imem_req_addr stable, ValidPs2=0, NOP_INSTR on InstructionPs2.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rstn low with 2 in-flight, response during reset -> all outputs at reset values, first post-reset fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests, buffers responses in a 2-entry FIFO, feeds the Ps2 register.
// Latency: a response reaches the Ps2 outputs one cycle after it arrives (FIFO bypass when empty), so Ps2 is valid two cycles after the request.
// Backpressure: a request is issued only while in-flight + buffered < 2; imem_req_ready stalls the request; stall_Ps2 holds Ps2 while the FIFO keeps filling.
//
// Ports:
//   clk, rstn                      - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      - fetch request channel (valid/ready handshake)
//   imem_rsp_valid/data            - in-order response channel, no backpressure
//   redirect_valid/pc              - single-cycle redirect pulse and target (low two bits ignored)
//   stall_Ps2                      - decode holds the current Ps2 instruction
//   InstructionPs2/PcPs2/ValidPs2  - registered instruction, its PC, and a real-instruction flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_Ps2,
  output logic [31:0] InstructionPs2,
  output logic [31:0] PcPs2,
  output logic        ValidPs2
);

  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  // DRAIN means stale responses from before a redirect are still on their way back.
  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_en_q;
  logic [1:0]  infl_q, infl_d;
  logic [1:0]  disc_q, disc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;

  logic [31:0] fifo_dat_q [0:1];
  logic [31:0] fifo_pc_q  [0:1];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_ps2_q, pc_ps2_d;
  logic        vld_q, vld_d;

  logic [2:0]  occupancy;
  logic        req_hs;
  logic        rsp_in;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        fifo_bypass;
  logic        fifo_push;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Stale requests still count here, so every response that comes back is
  // guaranteed a FIFO slot even if decode is stalled.
  assign occupancy      = {1'b0, infl_q} + {1'b0, cnt_q};
  assign imem_req_valid = req_en_q & (occupancy < 3'd2);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding cannot belong to us; ignore it.
  assign rsp_in   = imem_rsp_valid & (infl_q != 2'd0);
  assign rsp_drop = rsp_in & (redirect_valid | (state_q == ST_DRAIN));
  assign rsp_keep = rsp_in & ~rsp_drop;

  assign fifo_empty  = (cnt_q == 2'd0);
  assign fifo_pop    = ~redirect_valid & ~stall_Ps2 & ~fifo_empty;
  // With an empty FIFO the arriving word goes straight to Ps2.
  assign fifo_bypass = ~redirect_valid & ~stall_Ps2 & fifo_empty & rsp_keep;
  assign fifo_push   = rsp_keep & ~fifo_bypass;

  assign infl_d = infl_q + {1'b0, req_hs} - {1'b0, rsp_in};

  // FSM next state: a redirect marks everything still outstanding after this
  // edge (including a request handshaking right now) as stale.
  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    if (redirect_valid) begin
      disc_d  = infl_d;
      state_d = (infl_d != 2'd0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
        end
        ST_DRAIN: begin
          if (rsp_in) begin
            disc_d = disc_q - 2'd1;
            if (disc_q == 2'd1) begin
              state_d = ST_RUN;
            end
          end
        end
      endcase
    end
  end

  // Fetch PC and the PC tag of the next response that will be kept. Kept
  // responses are exactly the sequential requests since the last redirect,
  // so one incrementing tag replaces a per-request address queue.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      rsp_pc_d = redirect_tgt;
    end else begin
      if (req_hs) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
    end
  end

  // FIFO pointers and count; a redirect flushes it.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (redirect_valid) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (fifo_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (fifo_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
    end
  end

  // Ps2 register: redirect wins over stall; an idle cycle shows a bubble but
  // keeps the last PC.
  always_comb begin
    instr_d  = instr_q;
    pc_ps2_d = pc_ps2_q;
    vld_d    = vld_q;
    if (redirect_valid) begin
      instr_d = NOP_INSTR;
      vld_d   = 1'b0;
    end else if (!stall_Ps2) begin
      if (fifo_pop) begin
        instr_d  = fifo_dat_q[rd_ptr_q];
        pc_ps2_d = fifo_pc_q[rd_ptr_q];
        vld_d    = 1'b1;
      end else if (fifo_bypass) begin
        instr_d  = imem_rsp_data;
        pc_ps2_d = rsp_pc_q;
        vld_d    = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        vld_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC_AL;
      req_en_q <= 1'b0;
      infl_q   <= 2'd0;
      disc_q   <= 2'd0;
      rsp_pc_q <= RESET_PC_AL;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      instr_q  <= NOP_INSTR;
      pc_ps2_q <= RESET_PC;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      // Requests start one edge after reset release.
      req_en_q <= 1'b1;
      infl_q   <= infl_d;
      disc_q   <= disc_d;
      rsp_pc_q <= rsp_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      pc_ps2_q <= pc_ps2_d;
      vld_q    <= vld_d;
    end
  end

  // Storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_dat_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]  <= rsp_pc_q;
    end
  end

  assign InstructionPs2 = instr_q;
  assign PcPs2          = pc_ps2_q;
  assign ValidPs2       = vld_q;

endmodule
